ppu_ram_responder: RTL and testbench

- Memory-side end of the PPU's 4-pin serial RAM interface.
- Deserializes read requests arriving on the PPU's address pins and looks up 16-bit words in an internal RAM.
- Serializes each word back on the PPU's data pins after a fixed latency.
- Used as the FPGA/bench stand-in for the external RAM controller. A host write port fills the RAM.

---
 rtl/ppu_ram_if_pkg.sv | 16 +
 rtl/ppu_ram_nibble_serializer.sv | 41 ++++
 rtl/ppu_ram_responder.sv | 143 ++++++++++++++
 tb/tb_ppu_ram_responder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ppu_ram_if_pkg.sv
// rtl/ppu_ram_if_pkg.sv - constants and request FSM state type shared by both ends of the PPU serial RAM link
package ppu_ram_if_pkg;

    localparam int RAM_START_BIT    = 3;
    localparam int RAM_WORD_NIBBLES = 4;
    localparam int RAM_WORD_BITS    = 16;

    typedef enum logic [2:0] {
        IDLE,
        A0,
        A1,
        A2,
        A3
    } ram_req_state_e;

endpackage

// File: rtl/ppu_ram_nibble_serializer.sv
// rtl/ppu_ram_nibble_serializer.sv - emits a 16-bit word as four LSB-first nibbles, zeros when idle
module ppu_ram_nibble_serializer
    import ppu_ram_if_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     word_valid,
    input  logic [RAM_WORD_BITS-1:0] word,
    output logic [3:0]               nibble,
    output logic                     active
);

    logic [RAM_WORD_BITS-1:0] word_q, word_d;
    logic [2:0]               left_q, left_d;

    always_comb begin
        word_d = word_q;
        left_d = left_q;
        if (word_valid) begin
            word_d = word;
            left_d = 3'(RAM_WORD_NIBBLES);
        end else if (left_q != 3'd0) begin
            word_d = word_q >> 4;
            left_d = left_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_q <= '0;
            left_q <= '0;
        end else begin
            word_q <= word_d;
            left_q <= left_d;
        end
    end

    assign active = (left_q != 3'd0);
    assign nibble = active ? word_q[3:0] : 4'd0;

endmodule

// File: rtl/ppu_ram_responder.sv
// rtl/ppu_ram_responder.sv - RAM side of the PPU 4-pin serial link; PPU_RAM_RESPONDER_STATS_EN enables req_count
module ppu_ram_responder
    import ppu_ram_if_pkg::*;
#(
    parameter int RAM_PINS  = 4,
    parameter int ADDR_BITS = 10,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [RAM_PINS-1:0]  addr_pins,
    output logic [RAM_PINS-1:0]  data_pins,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [15:0]          wr_data,
    output logic                 busy,
    output logic [15:0]          req_count
);

    generate
        if (RAM_PINS != 4) begin : g_bad_pins
            $error("ppu_ram_responder: RAM_PINS must be 4");
        end
        if (LATENCY < 2 || LATENCY > 8) begin : g_bad_latency
            $error("ppu_ram_responder: LATENCY must be in 2..8");
        end
        if (ADDR_BITS < 1 || ADDR_BITS > 16) begin : g_bad_addr
            $error("ppu_ram_responder: ADDR_BITS must be in 1..16");
        end
    endgenerate

    // Stage 0 is the synchronous RAM output; the remaining stages pad out LATENCY.
    localparam int STAGES = LATENCY - 1;

    ram_req_state_e state_q, state_d;
    logic [11:0]    addr_q, addr_d;
    logic [15:0]    req_addr;
    logic [ADDR_BITS-1:0] rd_addr;
    logic           req_done;

    logic [STAGES-1:0]        vld_q, vld_d;
    logic [RAM_WORD_BITS-1:0] word_q [STAGES];
    logic [RAM_WORD_BITS-1:0] mem_q [2**ADDR_BITS];
    logic                     ser_active;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        req_done = 1'b0;
        case (state_q)
            IDLE: if (addr_pins[RAM_START_BIT]) state_d = A0;
            A0: begin
                addr_d[3:0] = addr_pins;
                state_d     = A1;
            end
            A1: begin
                addr_d[7:4] = addr_pins;
                state_d     = A2;
            end
            A2: begin
                addr_d[11:8] = addr_pins;
                state_d      = A3;
            end
            A3: begin
                req_done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The last nibble is still on the pins in A3, so the RAM is read in that same cycle.
    assign req_addr = {addr_pins, addr_q};
    assign rd_addr  = req_addr[ADDR_BITS-1:0];

    generate
        if (ADDR_BITS < 16) begin : g_addr_wrap
            logic unused_addr_bits;
            assign unused_addr_bits = ^req_addr[15:ADDR_BITS];
        end
    endgenerate

    always_comb begin
        vld_d    = '0;
        vld_d[0] = req_done;
        for (int i = 1; i < STAGES; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            vld_q   <= vld_d;
        end
    end

    // Non-reset datapath; reading before the write lands gives read-before-write on collisions.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        word_q[0] <= mem_q[rd_addr];
        for (int i = 1; i < STAGES; i++) begin
            word_q[i] <= word_q[i-1];
        end
    end

    ppu_ram_nibble_serializer u_serializer (
        .clk        (clk),
        .reset      (reset),
        .word_valid (vld_q[STAGES-1]),
        .word       (word_q[STAGES-1]),
        .nibble     (data_pins),
        .active     (ser_active)
    );

    assign busy = (state_q != IDLE) || (|vld_q) || ser_active;

`ifdef PPU_RAM_RESPONDER_STATS_EN
    logic [15:0] req_count_q, req_count_d;

    always_comb begin
        req_count_d = req_count_q;
        if (req_done) req_count_d = req_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) req_count_q <= '0;
        else       req_count_q <= req_count_d;
    end

    assign req_count = req_count_q;
`else
    assign req_count = '0;
`endif

endmodule

// File: tb/tb_ppu_ram_responder.sv
// tb/tb_ppu_ram_responder.sv - scoreboard bench for ppu_ram_responder
module tb_ppu_ram_responder;

    localparam int LAT = 2;
    localparam int AB  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  addr_pins = 4'd0;
    logic        wr_en = 1'b0;
    logic [AB-1:0] wr_addr = '0;
    logic [15:0] wr_data = 16'd0;
    logic [3:0]  data_pins;
    logic        busy;
    logic [15:0] req_count;

    ppu_ram_responder #(.RAM_PINS(4), .ADDR_BITS(AB), .LATENCY(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .addr_pins (addr_pins),
        .data_pins (data_pins),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .req_count (req_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          start;
        int          due;
        logic [15:0] word;
    } resp_t;

    resp_t       sb[$];
    logic [15:0] ram_model [2**AB];
    int          vectors = 0;
    int          miscompares = 0;
    int          frames_done = 0;
    bit          chk_en = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_count();
`ifdef PPU_RAM_RESPONDER_STATS_EN
        return 16'(frames_done);
`else
        return 16'd0;
`endif
    endfunction

    // Every response occupies [due, due+3] on data_pins; busy spans start+1 .. due+3.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [3:0] exp_nib;
            logic       exp_busy;
            exp_nib  = 4'd0;
            exp_busy = 1'b0;
            while (sb.size() > 0 && cyc > sb[0].due + 3) void'(sb.pop_front());
            foreach (sb[i]) begin
                if (cyc >= sb[i].start + 1 && cyc <= sb[i].due + 3) exp_busy = 1'b1;
                if (cyc >= sb[i].due && cyc <= sb[i].due + 3)
                    exp_nib = 4'((sb[i].word >> (4 * (cyc - sb[i].due))) & 16'hF);
            end
            check("data_pins", {12'd0, data_pins}, {12'd0, exp_nib});
            check("busy", {15'd0, busy}, {15'd0, exp_busy});
        end
    end

    task automatic drive(input logic [3:0] nib, input logic we, input logic [AB-1:0] wa, input logic [15:0] wd);
        @(posedge clk);
        #1;
        addr_pins = nib;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
    endtask

    task automatic idle(input int n, input bit rnd_wr);
        for (int i = 0; i < n; i++) begin
            logic we;
            logic [AB-1:0] wa;
            logic [15:0] wd;
            we = rnd_wr && ($urandom_range(3) == 0);
            wa = AB'($urandom);
            wd = 16'($urandom);
            drive(4'($urandom_range(7)), we, wa, wd);
            if (we) ram_model[wa] = wd;
        end
    endtask

    task automatic send_frame(input logic [15:0] a, input logic [2:0] slo, input bit rnd_wr,
                              input bit force_wr, input logic [15:0] fwd);
        resp_t r;
        for (int k = 0; k < 5; k++) begin
            logic we;
            logic [AB-1:0] wa;
            logic [15:0] wd;
            logic [3:0] nib;
            we = 1'b0;
            wa = '0;
            wd = 16'd0;
            if (rnd_wr && $urandom_range(3) == 0) begin
                we = 1'b1;
                wa = AB'($urandom);
                wd = 16'($urandom);
                if (k == 4 && $urandom_range(1) == 0) wa = a[AB-1:0];
            end
            if (k == 4 && force_wr) begin
                we = 1'b1;
                wa = a[AB-1:0];
                wd = fwd;
            end
            nib = (k == 0) ? {1'b1, slo} : a[4*(k-1) +: 4];
            drive(nib, we, wa, wd);
            if (k == 0) begin
                r.start = cyc;
                r.due   = cyc + 4 + LAT;
                r.word  = 16'd0;
                sb.push_back(r);
            end
            if (k == 4) begin
                sb[sb.size()-1].word = ram_model[a[AB-1:0]];
                frames_done++;
            end
            if (we) ram_model[wa] = wd;
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        reset     = 1'b1;
        addr_pins = 4'd0;
        wr_en     = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        frames_done = 0;
        @(negedge clk);
        check("rst data_pins", {12'd0, data_pins}, 16'd0);
        check("rst busy", {15'd0, busy}, 16'd0);
        check("rst req_count", req_count, 16'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("init data_pins", {12'd0, data_pins}, 16'd0);
        check("init busy", {15'd0, busy}, 16'd0);
        check("init req_count", req_count, 16'd0);
        chk_en = 1'b1;

        for (int i = 0; i < 2**AB; i++) begin
            logic [15:0] d;
            d = 16'($urandom);
            drive(4'($urandom_range(7)), 1'b1, AB'(i), d);
            ram_model[i] = d;
        end
        drive(4'd0, 1'b1, AB'(5), 16'hBEEF);
        ram_model[5] = 16'hBEEF;
        drive(4'd0, 1'b1, AB'(6), 16'h1234);
        ram_model[6] = 16'h1234;
        idle(2, 1'b0);

        send_frame(16'h0005, 3'd0, 1'b0, 1'b0, 16'd0);
        idle(4, 1'b0);
        send_frame(16'h0005, 3'd0, 1'b0, 1'b0, 16'd0);
        send_frame(16'h0006, 3'd0, 1'b0, 1'b0, 16'd0);
        idle(8, 1'b0);
        send_frame(16'hFC05, 3'd7, 1'b0, 1'b0, 16'd0);
        idle(6, 1'b0);
        send_frame(16'h0005, 3'd0, 1'b0, 1'b1, 16'h0000);
        idle(2, 1'b0);
        send_frame(16'h0005, 3'd0, 1'b0, 1'b0, 16'd0);
        idle(8, 1'b0);
        check("req_count directed", req_count, exp_count());

        send_frame(16'h0006, 3'd0, 1'b0, 1'b0, 16'd0);
        idle(3, 1'b0);
        pulse_reset();

        send_frame(16'h0005, 3'd0, 1'b0, 1'b0, 16'd0);
        send_frame(16'h0006, 3'd0, 1'b0, 1'b0, 16'd0);
        idle(1, 1'b0);
        send_frame(16'h8C05, 3'd3, 1'b0, 1'b0, 16'd0);
        idle(8, 1'b0);
        check("req_count three", req_count, exp_count());
        pulse_reset();

        for (int f = 0; f < 80; f++) begin
            send_frame(16'($urandom), 3'($urandom_range(7)), 1'b1, 1'b0, 16'd0);
            idle($urandom_range(0, 3), 1'b1);
        end
        idle(12, 1'b0);
        check("req_count random", req_count, exp_count());

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
